// File: rtl/class_argmax_if.sv
// Score-vector input and argmax-result bus of class_argmax.
// Signal names are seen from the argmax block (i_ = into it, o_ = out of it).
interface class_argmax_if #(
  parameter int CLASSES_QNT = 10,
  parameter int SCORE_WIDTH = 32
);
  localparam int IDX_W = $clog2(CLASSES_QNT);

  // Handshake: i_valid is a one-cycle strobe with no back-pressure. o_valid rises
  // with a result and holds every result field stable until a clock-enabled edge
  // sees o_valid && i_ready; that edge is the transfer.
  logic                                  i_valid;
  logic [CLASSES_QNT-1:0][SCORE_WIDTH-1:0] i_classes;
  logic                                  i_ready;
  logic                                  o_valid;
  logic [IDX_W-1:0]                      o_class;
  logic [SCORE_WIDTH-1:0]                o_score;
  logic [SCORE_WIDTH-1:0]                o_second;
  logic [SCORE_WIDTH:0]                  o_margin;
  logic                                  o_confident;
  logic                                  o_busy;
  logic [15:0]                           o_drop_cnt;
  logic [1:0]                            o_dbg_state;

  modport master (
    output i_valid, i_classes, i_ready,
    input  o_valid, o_class, o_score, o_second, o_margin, o_confident,
           o_busy, o_drop_cnt, o_dbg_state
  );

  modport slave (
    input  i_valid, i_classes, i_ready,
    output o_valid, o_class, o_score, o_second, o_margin, o_confident,
           o_busy, o_drop_cnt, o_dbg_state
  );
endinterface

// File: rtl/class_argmax.sv
// Serial argmax over the CNN class-score vector, one class per cycle, with a
// one-deep pending slot for frames that arrive while busy and a valid/ready result.
module class_argmax #(
  parameter int CLASSES_QNT = 10,
  parameter int SCORE_WIDTH = 32,
  parameter logic signed [SCORE_WIDTH:0] MARGIN_THRESH = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_en,
  class_argmax_if.slave bus
);
  localparam int IDX_W = $clog2(CLASSES_QNT);
  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(CLASSES_QNT - 1);
  localparam logic signed [SCORE_WIDTH-1:0] SCORE_MIN = {1'b1, {(SCORE_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  typedef logic [CLASSES_QNT-1:0][SCORE_WIDTH-1:0] frame_t;

  state_t                         r_state;
  state_t                         w_next_state;
  frame_t                         r_work;
  frame_t                         r_pend;
  frame_t                         w_load_frame;
  logic                           r_pend_full;
  logic [IDX_W-1:0]               r_k;
  logic [IDX_W-1:0]               r_idx;
  logic [IDX_W-1:0]               w_idx;
  logic signed [SCORE_WIDTH-1:0]  r_best;
  logic signed [SCORE_WIDTH-1:0]  r_second;
  logic signed [SCORE_WIDTH-1:0]  w_cur;
  logic signed [SCORE_WIDTH-1:0]  w_best;
  logic signed [SCORE_WIDTH-1:0]  w_second;
  logic signed [SCORE_WIDTH:0]    w_margin;
  logic                           w_hs;
  logic                           w_last;
  logic                           w_load;
  logic                           w_pend_push;
  logic                           w_pend_pop;
  logic                           w_drop;

  logic                           r_o_valid;
  logic [IDX_W-1:0]               r_o_class;
  logic [SCORE_WIDTH-1:0]         r_o_score;
  logic [SCORE_WIDTH-1:0]         r_o_second;
  logic [SCORE_WIDTH:0]           r_o_margin;
  logic                           r_o_confident;
  logic [15:0]                    r_drop_cnt;

  assign w_hs   = r_o_valid && bus.i_ready;
  assign w_last = (r_state == S_SCAN) && (r_k == LAST_K);

  // One compare step of the scan; strict > keeps the lowest index on ties.
  always_comb begin
    w_cur    = r_work[r_k];
    w_best   = r_best;
    w_second = r_second;
    w_idx    = r_idx;
    if (w_cur > r_best) begin
      w_second = r_best;
      w_best   = w_cur;
      w_idx    = r_k;
    end else if (w_cur > r_second) begin
      w_second = w_cur;
    end
    w_margin = {w_best[SCORE_WIDTH-1], w_best} - {w_second[SCORE_WIDTH-1], w_second};
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_frame = bus.i_classes;
    w_pend_pop   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_valid) begin
          w_next_state = S_SCAN;
          w_load       = 1'b1;
        end
      end
      S_SCAN: begin
        if (w_last) w_next_state = S_HOLD;
      end
      S_HOLD: begin
        if (w_hs) begin
          if (r_pend_full) begin
            w_next_state = S_SCAN;
            w_load       = 1'b1;
            w_load_frame = r_pend;
            w_pend_pop   = 1'b1;
          end else if (bus.i_valid) begin
            w_next_state = S_SCAN;
            w_load       = 1'b1;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
    // A frame not loaded straight into working lands in pending if that slot is
    // free this edge (empty, or being drained into working), otherwise it is lost.
    w_pend_push = bus.i_valid && !(w_load && !w_pend_pop) && (!r_pend_full || w_pend_pop);
    w_drop      = bus.i_valid && !(w_load && !w_pend_pop) && r_pend_full && !w_pend_pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_state <= S_IDLE;
    else if (clk_en) r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work        <= '0;
      r_pend        <= '0;
      r_pend_full   <= 1'b0;
      r_k           <= '0;
      r_idx         <= '0;
      r_best        <= '0;
      r_second      <= '0;
      r_o_valid     <= 1'b0;
      r_o_class     <= '0;
      r_o_score     <= '0;
      r_o_second    <= '0;
      r_o_margin    <= '0;
      r_o_confident <= 1'b0;
      r_drop_cnt    <= '0;
    end else if (clk_en) begin
      if (w_load) begin
        r_work   <= w_load_frame;
        r_best   <= w_load_frame[0];
        r_idx    <= '0;
        r_second <= SCORE_MIN;
        r_k      <= IDX_W'(1);
      end else if (r_state == S_SCAN) begin
        r_best   <= w_best;
        r_second <= w_second;
        r_idx    <= w_idx;
        if (!w_last) r_k <= r_k + IDX_W'(1);
      end

      if (w_last) begin
        r_o_valid     <= 1'b1;
        r_o_class     <= w_idx;
        r_o_score     <= w_best;
        r_o_second    <= w_second;
        r_o_margin    <= w_margin;
        r_o_confident <= (w_margin > MARGIN_THRESH);
      end else if (w_hs) begin
        r_o_valid     <= 1'b0;
      end

      if (w_pend_push) begin
        r_pend      <= bus.i_classes;
        r_pend_full <= 1'b1;
      end else if (w_pend_pop) begin
        r_pend_full <= 1'b0;
      end

      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign bus.o_valid     = r_o_valid;
  assign bus.o_class     = r_o_class;
  assign bus.o_score     = r_o_score;
  assign bus.o_second    = r_o_second;
  assign bus.o_margin    = r_o_margin;
  assign bus.o_confident = r_o_confident;
  assign bus.o_busy      = (r_state != S_IDLE) || r_pend_full;
  assign bus.o_drop_cnt  = r_drop_cnt;
  assign bus.o_dbg_state = r_state;
endmodule

// File: tb/tb_class_argmax.sv
// Bench for class_argmax: directed corner frames plus randomized traffic checked
// every cycle against a frame-level model of argmax, pending slot and drops.
module tb_class_argmax;
  localparam int N  = 10;
  localparam int W  = 32;
  localparam int IW = $clog2(N);
  localparam int MW = W + 1;

  typedef logic [N-1:0][W-1:0] frame_t;
  typedef struct packed {
    logic [IW-1:0] cls;
    logic [W-1:0]  score;
    logic [W-1:0]  second;
    logic [W:0]    margin;
    logic          conf;
  } res_t;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic clk_en = 1'b1;
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_err  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  class_argmax_if #(.CLASSES_QNT(N), .SCORE_WIDTH(W)) bus ();

  class_argmax #(.CLASSES_QNT(N), .SCORE_WIDTH(W), .MARGIN_THRESH('0)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .bus    (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic res_t ref_result(input frame_t f);
    res_t   r;
    int     bi;
    longint b;
    longint s;
    longint v;
    bi = 0;
    for (int i = 1; i < N; i++)
      if (longint'($signed(f[i])) > longint'($signed(f[bi]))) bi = i;
    b = longint'($signed(f[bi]));
    s = -(longint'(1) <<< 62);
    for (int j = 0; j < N; j++) begin
      v = longint'($signed(f[j]));
      if (j != bi && v > s) s = v;
    end
    r.cls    = IW'(bi);
    r.score  = f[bi];
    r.second = W'(s);
    r.margin = MW'(b - s);
    r.conf   = (b - s) > 0;
    return r;
  endfunction

  res_t exp_q[$];
  bit   m_work  = 1'b0;
  bit   m_pend  = 1'b0;
  bit   m_valid = 1'b0;
  bit   m_hs    = 1'b0;
  int   m_cnt   = 0;
  int   m_drop  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_work = 1'b0; m_pend = 1'b0; m_valid = 1'b0; m_cnt = 0; m_drop = 0;
      exp_q.delete();
    end else if (clk_en) begin
      m_hs = m_valid && bus.i_ready;
      if (m_work && !m_valid) begin
        m_cnt--;
        if (m_cnt == 0) m_valid = 1'b1;
      end else if (m_hs) begin
        m_valid = 1'b0;
        void'(exp_q.pop_front());
        if (m_pend) begin
          m_pend = 1'b0;
          m_cnt  = N - 1;
        end else begin
          m_work = 1'b0;
        end
      end
      if (bus.i_valid) begin
        if (!m_work) begin
          m_work = 1'b1;
          m_cnt  = N - 1;
          exp_q.push_back(ref_result(bus.i_classes));
        end else if (!m_pend) begin
          m_pend = 1'b1;
          exp_q.push_back(ref_result(bus.i_classes));
        end else if (m_drop < 65535) begin
          m_drop++;
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    check("o_valid", bus.o_valid, m_valid);
    check("o_busy", bus.o_busy, m_work || m_pend);
    check("o_drop_cnt", bus.o_drop_cnt, 16'(m_drop));
    if (m_valid) begin
      check("o_class", bus.o_class, exp_q[0].cls);
      check("o_score", bus.o_score, exp_q[0].score);
      check("o_second", bus.o_second, exp_q[0].second);
      check("o_margin", bus.o_margin, exp_q[0].margin);
      check("o_confident", bus.o_confident, exp_q[0].conf);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input frame_t f);
    bus.i_classes = f;
    bus.i_valid   = 1'b1;
    tick();
    bus.i_valid   = 1'b0;
  endtask

  task automatic wait_valid(input int e0, input string name, output int lat);
    int guard;
    guard = 0;
    while (bus.o_valid !== 1'b1 && guard < 60) begin
      tick();
      guard++;
    end
    lat = cyc - e0;
    check({name, "_seen"}, bus.o_valid, 1'b1);
  endtask

  function automatic frame_t fill(input int v);
    frame_t f;
    for (int i = 0; i < N; i++) f[i] = W'(v);
    return f;
  endfunction

  task automatic run_lit(input frame_t f, input string name, input logic [IW-1:0] cls,
                         input logic [W-1:0] score, input logic [W-1:0] second,
                         input logic [W:0] margin, input logic conf);
    res_t r;
    int   e0;
    int   lat;
    r = ref_result(f);
    check({name, "_model_class"}, r.cls, cls);
    check({name, "_model_second"}, r.second, second);
    check({name, "_model_margin"}, r.margin, margin);
    send(f);
    e0 = cyc;
    wait_valid(e0, name, lat);
    check({name, "_latency"}, lat, 9);
    check({name, "_class"}, bus.o_class, cls);
    check({name, "_score"}, bus.o_score, score);
    check({name, "_second"}, bus.o_second, second);
    check({name, "_margin"}, bus.o_margin, margin);
    check({name, "_confident"}, bus.o_confident, conf);
    tick();
    check({name, "_pulse_width"}, bus.o_valid, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    frame_t f;
    frame_t fa;
    frame_t fb;
    int     e0;
    int     lat;
    int     hits;

    bus.i_valid   = 1'b0;
    bus.i_classes = '0;
    bus.i_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", bus.o_valid, 1'b0);
    check("rst_class", bus.o_class, '0);
    check("rst_score", bus.o_score, '0);
    check("rst_second", bus.o_second, '0);
    check("rst_margin", bus.o_margin, '0);
    check("rst_confident", bus.o_confident, 1'b0);
    check("rst_busy", bus.o_busy, 1'b0);
    check("rst_drop", bus.o_drop_cnt, '0);
    check("rst_state", bus.o_dbg_state, 2'd0);
    rst_n = 1'b1;
    tick();

    f = fill(-10); f[0] = W'(5); f[3] = W'(100); f[7] = W'(40);
    run_lit(f, "peak", 4'd3, 32'd100, 32'd40, 33'd60, 1'b1);
    run_lit(fill(-7), "all_eq", 4'd0, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 33'd0, 1'b0);
    f = fill(0); f[2] = 32'h7FFF_FFFF; f[5] = 32'h8000_0000;
    run_lit(f, "extreme", 4'd2, 32'h7FFF_FFFF, 32'd0, 33'h0_7FFF_FFFF, 1'b1);
    for (int i = 0; i < N - 1; i++) f[i] = W'(-100 - i);
    f[N-1] = 32'hFFFF_FFFF;
    run_lit(f, "last_wins", 4'd9, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 33'd99, 1'b1);

    // Back-pressure: first frame held, second pending, third dropped.
    bus.i_ready = 1'b0;
    fa = fill(0); fa[4] = W'(50);
    send(fa); repeat (11) tick();
    fb = fill(0); fb[6] = W'(77);
    send(fb); repeat (11) tick();
    f = fill(0); f[1] = W'(9);
    send(f);
    check("bp_drop_cnt", bus.o_drop_cnt, 16'd1);
    check("bp_hold_valid", bus.o_valid, 1'b1);
    check("bp_hold_class", bus.o_class, 4'd4);
    check("bp_busy", bus.o_busy, 1'b1);
    bus.i_ready = 1'b1;
    tick();
    e0 = cyc;
    check("bp_after_hs_valid", bus.o_valid, 1'b0);
    wait_valid(e0, "bp_second", lat);
    check("bp_second_latency", lat, 9);
    check("bp_second_class", bus.o_class, 4'd6);
    check("bp_second_score", bus.o_score, 32'd77);
    tick();
    check("bp_done_busy", bus.o_busy, 1'b0);

    // New frame on the very edge its predecessor is accepted.
    fa = fill(1); fa[8] = W'(20);
    send(fa);
    e0 = cyc;
    wait_valid(e0, "b2b_a", lat);
    fb = fill(-3); fb[2] = W'(-2);
    send(fb);
    e0 = cyc;
    check("b2b_gap_valid", bus.o_valid, 1'b0);
    check("b2b_drop_cnt", bus.o_drop_cnt, 16'd1);
    wait_valid(e0, "b2b_b", lat);
    check("b2b_latency", lat, 9);
    check("b2b_class", bus.o_class, 4'd2);
    check("b2b_score", bus.o_score, 32'hFFFF_FFFE);
    tick();

    // Asynchronous reset mid-scan with the pending slot full.
    fa = fill(0); fa[5] = W'(11);
    fb = fill(0); fb[0] = W'(12);
    send(fa);
    send(fb);
    tick();
    check("arst_busy_before", bus.o_busy, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid", bus.o_valid, 1'b0);
    check("arst_busy", bus.o_busy, 1'b0);
    check("arst_drop", bus.o_drop_cnt, '0);
    check("arst_class", bus.o_class, '0);
    check("arst_score", bus.o_score, '0);
    check("arst_second", bus.o_second, '0);
    check("arst_margin", bus.o_margin, '0);
    check("arst_state", bus.o_dbg_state, 2'd0);
    tick();
    rst_n = 1'b1;
    hits = 0;
    repeat (30) begin
      tick();
      if (bus.o_valid === 1'b1) hits++;
    end
    check("arst_no_result", hits, 0);

    // Clock enable low for 5 edges mid-scan; a strobe during the freeze is ignored.
    fa = fill(2); fa[7] = W'(3);
    send(fa);
    e0 = cyc;
    tick(); tick();
    clk_en = 1'b0;
    fb = fill(0); fb[1] = W'(99);
    send(fb);
    repeat (4) tick();
    clk_en = 1'b1;
    wait_valid(e0, "cen", lat);
    check("cen_latency", lat, 14);
    check("cen_class", bus.o_class, 4'd7);
    tick();
    check("cen_ignored_frame", bus.o_busy, 1'b0);

    // Randomized traffic against the model.
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0, 3:    f[i] = W'($urandom_range(0, 8)) - W'(4);
          1:       f[i] = W'($urandom);
          default: f[i] = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        endcase
      end
      bus.i_classes = f;
      bus.i_valid   = ($urandom_range(0, 99) < 12);
      bus.i_ready   = ($urandom_range(0, 3) != 0);
      clk_en        = ($urandom_range(0, 15) != 0);
      tick();
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    clk_en      = 1'b1;
    repeat (40) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
